// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - step encodings, quadrature decode function and counter-width helpers
package quad_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  localparam int DEF_FILTER_LEN = 100;
  localparam int DEF_VEL_WINDOW = 32000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Position of an {A,B} state along the forward cycle 00->10->11->01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b10:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  function automatic step_e decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    step_e      s;
    d = gray_pos(cur) - gray_pos(prev);
    case (d)
      2'd0:    s = STEP_NONE;
      2'd1:    s = STEP_UP;
      2'd3:    s = STEP_DN;
      default: s = STEP_ILL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// rtl/quad_channel.sv - one encoder channel: sync, glitch filter, 4x decode, position, velocity
module quad_channel
  import quad_pkg::*;
#(
  parameter int COUNT_W    = 24,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int SATURATE   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      quad_a,
  input  logic                      quad_b,
  input  logic                      clear,
  input  logic                      error_clr,
  input  logic                      init,
  input  logic                      win_end,
  output logic signed [COUNT_W-1:0] count,
  output logic signed [COUNT_W-1:0] velocity,
  output logic                      error
);

  localparam int FILT_W = cnt_w(FILTER_LEN - 1);
  localparam logic signed [COUNT_W-1:0] CNT_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic signed [COUNT_W-1:0] CNT_MIN = {1'b1, {(COUNT_W-1){1'b0}}};

  logic [1:0]                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]                filt_q, filt_d, prev_q, prev_d;
  logic [FILT_W-1:0]         fcnt_q [0:1];
  logic [FILT_W-1:0]         fcnt_d [0:1];
  logic signed [COUNT_W-1:0] count_q, count_d, snap_q, snap_d, vel_q, vel_d;
  logic                      error_q, error_d;
  step_e                     step;

  always_comb begin
    sync1_d = {quad_a, quad_b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int p = 0; p < 2; p++) begin
      fcnt_d[p] = '0;
    end
    if (init) begin
      filt_d = sync2_q;
    end else begin
      // Counter runs only while sync disagrees; any agreement drops it back to zero.
      for (int p = 0; p < 2; p++) begin
        if (sync2_q[p] != filt_q[p]) begin
          if (fcnt_q[p] == FILT_W'(FILTER_LEN - 1)) begin
            filt_d[p] = sync2_q[p];
          end else begin
            fcnt_d[p] = fcnt_q[p] + 1'b1;
          end
        end
      end
    end
    prev_d = init ? filt_d : filt_q;
    step   = init ? STEP_NONE : decode(prev_q, filt_q);
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (step == STEP_UP) begin
      if (!(SATURATE != 0 && count_q == CNT_MAX)) count_d = count_q + 1'b1;
    end else if (step == STEP_DN) begin
      if (!(SATURATE != 0 && count_q == CNT_MIN)) count_d = count_q - 1'b1;
    end

    error_d = error_q;
    if (error_clr) begin
      error_d = 1'b0;
    end else if (step == STEP_ILL) begin
      error_d = 1'b1;
    end

    // Window delta uses the pre-step, pre-clear position.
    vel_d  = vel_q;
    snap_d = snap_q;
    if (win_end) begin
      vel_d  = count_q - snap_q;
      snap_d = count_q;
    end
    if (clear) snap_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      count_q   <= '0;
      snap_q    <= '0;
      vel_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      prev_q    <= prev_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
      count_q   <= count_d;
      snap_q    <= snap_d;
      vel_q     <= vel_d;
      error_q   <= error_d;
    end
  end

  assign count    = count_q;
  assign velocity = vel_q;
  assign error    = error_q;

endmodule

// File: rtl/quad_decoder_multi.sv
// rtl/quad_decoder_multi.sv - N-channel quadrature decoder with shared velocity window
module quad_decoder_multi
  import quad_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int COUNT_W    = 24,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int VEL_WINDOW = DEF_VEL_WINDOW,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           quad_a,
  input  logic [CHANNELS-1:0]           quad_b,
  input  logic [CHANNELS-1:0]           clear,
  input  logic                          error_clr,
  output logic [CHANNELS*COUNT_W-1:0]   count,
  output logic [CHANNELS*COUNT_W-1:0]   velocity,
  output logic                          vel_valid,
  output logic [CHANNELS-1:0]           error
);

  localparam int INIT_LEN = FILTER_LEN + 2;
  localparam int INIT_W   = cnt_w(INIT_LEN);
  localparam int WIN_W    = cnt_w(VEL_WINDOW - 1);

  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic              vel_valid_q, vel_valid_d;
  logic              init, win_end;

  always_comb begin
    init        = (init_cnt_q != INIT_W'(INIT_LEN));
    init_cnt_d  = init ? init_cnt_q + 1'b1 : init_cnt_q;
    win_end     = (win_cnt_q == WIN_W'(VEL_WINDOW - 1));
    win_cnt_d   = win_end ? '0 : win_cnt_q + 1'b1;
    vel_valid_d = win_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_q  <= '0;
      win_cnt_q   <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      win_cnt_q   <= win_cnt_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign vel_valid = vel_valid_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_channel #(
      .COUNT_W    (COUNT_W),
      .FILTER_LEN (FILTER_LEN),
      .SATURATE   (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset_n),
      .quad_a    (quad_a[i]),
      .quad_b    (quad_b[i]),
      .clear     (clear[i]),
      .error_clr (error_clr),
      .init      (init),
      .win_end   (win_end),
      .count     (count[i*COUNT_W +: COUNT_W]),
      .velocity  (velocity[i*COUNT_W +: COUNT_W]),
      .error     (error[i])
    );
  end

endmodule
